// File: rtl/fpga_ram_bist_pkg.sv
// rtl/fpga_ram_bist_pkg.sv - shared states and test patterns for the RAM BIST sequencer
package fpga_ram_bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_W0, S_R0, S_DRN0, S_W1, S_R1, S_DRN1, S_DONE
   } bist_state_e;

   localparam int PAT_W = 40;
   localparam logic [PAT_W-1:0] PAT_A = 40'hAAAA_AAAAAA;
   localparam logic [PAT_W-1:0] PAT_5 = 40'h5555_555555;

   // Checkerboard pattern selected by the address LSB
   function automatic logic [PAT_W-1:0] pat40(input logic a0);
      return a0 ? PAT_5 : PAT_A;
   endfunction

   // Bit i of the pattern, repeating every PAT_W bits for wider data
   function automatic logic pat_bit(input int i, input logic a0);
      logic [PAT_W-1:0] p;
      p = pat40(a0);
      return p[6'(i % PAT_W)];
   endfunction

endpackage

// File: rtl/fpga_ram_bist_expect_pipe.sv
// rtl/fpga_ram_bist_expect_pipe.sv - read-latency delay line of {valid, ram, addr, expected}
module fpga_ram_bist_expect_pipe #(
   parameter int RD_LAT = 2,
   parameter int W      = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [RD_LAT-1:0] v_q;
   logic [W-1:0]      d_q [RD_LAT];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v_q <= '0;
         for (int i = 0; i < RD_LAT; i++) d_q[i] <= '0;
      end else begin
         v_q[0] <= in_valid;
         d_q[0] <= in_data;
         for (int i = 1; i < RD_LAT; i++) begin
            v_q[i] <= v_q[i-1];
            d_q[i] <= d_q[i-1];
         end
      end
   end

   assign out_valid = v_q[RD_LAT-1];
   assign out_data  = d_q[RD_LAT-1];

endmodule

// File: rtl/fpga_ram_bist_ctrl.sv
// rtl/fpga_ram_bist_ctrl.sv - BIST sequencer: per-RAM write/read checkerboard march with first-fail capture
module fpga_ram_bist_ctrl
   import fpga_ram_bist_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 40,
   parameter int NUM_RAMS = 4,
   parameter int RD_LAT   = 2,
   localparam int RAM_W   = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   output logic                bist_enable_o,
   output logic [NUM_RAMS-1:0] y_select_o,
   output logic [ADDR_W-1:0]   bist_addr_o,
   output logic [DATA_W-1:0]   bist_wrdata_o,
   output logic                bist_we_o,
   input  logic [DATA_W-1:0]   bist_rddata_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                fail_o,
   output logic [RAM_W-1:0]    fail_ram_o,
   output logic [ADDR_W-1:0]   fail_addr_o
);

   localparam int DRN_W = $clog2(RD_LAT + 1);
   localparam int PW    = RAM_W + ADDR_W + DATA_W;

   bist_state_e        state_q, state_d;
   logic [RAM_W-1:0]   k_q, k_d;
   logic [ADDR_W-1:0]  a_q, a_d;
   logic [DRN_W-1:0]   drn_q, drn_d;
   logic [DATA_W-1:0]  pat_d, pat_q, exp_q;
   logic               start_ok, run_d, access_d, wr_d;
   logic               pv;
   logic [PW-1:0]      pdata;
   logic               mismatch;

   assign start_ok = start_i && (state_q == S_IDLE || state_q == S_DONE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         a_q     <= '0;
         drn_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         drn_q   <= drn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      drn_d   = '0;
      case (state_q)
         S_IDLE, S_DONE: if (start_i) begin
            state_d = S_W0;
            k_d     = '0;
            a_d     = '0;
         end
         S_W0, S_R0, S_W1, S_R1: begin
            // Address wraps to 0 naturally on the last access of each phase
            a_d = a_q + ADDR_W'(1);
            if (a_q == '1) begin
               case (state_q)
                  S_W0:    state_d = S_R0;
                  S_R0:    state_d = S_DRN0;
                  S_W1:    state_d = S_R1;
                  default: state_d = S_DRN1;
               endcase
            end
         end
         S_DRN0: begin
            drn_d = drn_q + DRN_W'(1);
            if (drn_q == DRN_W'(RD_LAT - 1)) begin
               state_d = S_W1;
               drn_d   = '0;
            end
         end
         S_DRN1: begin
            drn_d = drn_q + DRN_W'(1);
            if (drn_q == DRN_W'(RD_LAT - 1)) begin
               drn_d = '0;
               if (k_q == RAM_W'(NUM_RAMS - 1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_W0;
                  k_d     = k_q + RAM_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < DATA_W; i++) begin
         pat_d[i] = pat_bit(i, a_d[0]);
         pat_q[i] = pat_bit(i, a_q[0]);
      end
      run_d    = !(state_d == S_IDLE || state_d == S_DONE);
      wr_d     = (state_d == S_W0 || state_d == S_W1);
      access_d = wr_d || state_d == S_R0 || state_d == S_R1;
      exp_q    = (state_q == S_R0) ? pat_q : ~pat_q;
   end

   // state_q/a_q match the registered outputs, so this tags the read on the bus this cycle
   fpga_ram_bist_expect_pipe #(.RD_LAT(RD_LAT), .W(PW)) u_expect_pipe (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_valid  (state_q == S_R0 || state_q == S_R1),
      .in_data   ({k_q, a_q, exp_q}),
      .out_valid (pv),
      .out_data  (pdata)
   );

   assign mismatch = pv && (bist_rddata_i != pdata[DATA_W-1:0]);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bist_enable_o <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         y_select_o    <= '0;
         bist_addr_o   <= '0;
         bist_we_o     <= 1'b0;
         bist_wrdata_o <= '0;
         fail_o        <= 1'b0;
         fail_ram_o    <= '0;
         fail_addr_o   <= '0;
      end else begin
         bist_enable_o <= run_d;
         busy_o        <= run_d;
         done_o        <= (state_d == S_DONE);
         y_select_o    <= run_d ? (NUM_RAMS'(1) << k_d) : '0;
         bist_addr_o   <= access_d ? a_d : '0;
         bist_we_o     <= wr_d;
         bist_wrdata_o <= (state_d == S_W0) ? pat_d : (state_d == S_W1) ? ~pat_d : '0;
         if (start_ok) begin
            fail_o      <= 1'b0;
            fail_ram_o  <= '0;
            fail_addr_o <= '0;
         end else if (mismatch && !fail_o) begin
            fail_o      <= 1'b1;
            fail_ram_o  <= pdata[PW-1 -: RAM_W];
            fail_addr_o <= pdata[DATA_W +: ADDR_W];
         end
      end
   end

endmodule

// File: tb/tb_fpga_ram_bist_ctrl.sv
// tb/tb_fpga_ram_bist_ctrl.sv - directed bench with a 4-RAM plus forwarding-chain model
module tb_fpga_ram_bist_ctrl;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 40;
   localparam int NR     = 4;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              start_i = 1'b0;
   logic              bist_enable_o, bist_we_o, busy_o, done_o, fail_o;
   logic [NR-1:0]     y_select_o;
   logic [ADDR_W-1:0] bist_addr_o, fail_addr_o;
   logic [DATA_W-1:0] bist_wrdata_o, bist_rddata_i;
   logic [1:0]        fail_ram_o;

   int tests = 0;
   int failed = 0;
   int cyc = 0;

   logic [NR-1:0] ysel_log [0:200];
   logic          done_log [0:200];
   logic          busy_log [0:200];
   logic          fail_log [0:200];

   logic [DATA_W-1:0] mem    [NR][8];
   logic [DATA_W-1:0] stuck0 [NR][8];
   logic [DATA_W-1:0] fwd1 = '0, fwd2 = '0;
   int                sel;

   always #5 clk_i = ~clk_i;

   fpga_ram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RAMS(NR), .RD_LAT(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .bist_enable_o(bist_enable_o), .y_select_o(y_select_o),
      .bist_addr_o(bist_addr_o), .bist_wrdata_o(bist_wrdata_o), .bist_we_o(bist_we_o),
      .bist_rddata_i(bist_rddata_i), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
      .fail_ram_o(fail_ram_o), .fail_addr_o(fail_addr_o)
   );

   always_comb begin
      sel = -1;
      for (int i = 0; i < NR; i++) if (y_select_o[i]) sel = i;
   end

   // RAM read registered, then one registered forwarding stage: two cycles total
   always @(posedge clk_i) begin
      if (sel >= 0) begin
         if (bist_we_o) mem[sel][bist_addr_o] <= bist_wrdata_o & ~stuck0[sel][bist_addr_o];
         fwd1 <= mem[sel][bist_addr_o];
      end else begin
         fwd1 <= '0;
      end
      fwd2 <= fwd1;
   end
   assign bist_rddata_i = fwd2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic log_now();
      ysel_log[cyc] = y_select_o;
      done_log[cyc] = done_o;
      busy_log[cyc] = busy_o;
      fail_log[cyc] = fail_o;
   endtask

   task automatic start_run();
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cyc = 1;
      log_now();
   endtask

   task automatic run_until(input int last, input int pulse_at);
      while (cyc < last) begin
         start_i = (cyc == pulse_at);
         @(posedge clk_i); #1;
         start_i = 1'b0;
         cyc++;
         log_now();
      end
   endtask

   task automatic clear_faults();
      for (int r = 0; r < NR; r++)
         for (int a = 0; a < 8; a++) stuck0[r][a] = '0;
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({bist_enable_o, y_select_o, bist_addr_o, bist_wrdata_o, bist_we_o,
                  busy_o, done_o, fail_o, fail_ram_o, fail_addr_o});
   endfunction

   initial begin
      clear_faults();
      // Reset state
      #1;
      chk("reset_outs", all_outs(), 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("idle_outs", all_outs(), 64'd0);

      // Clean run
      start_run();
      chk("c1_busy", 64'(busy_o), 64'd1);
      chk("c1_enable", 64'(bist_enable_o), 64'd1);
      chk("c1_we", 64'(bist_we_o), 64'd1);
      chk("c1_addr", 64'(bist_addr_o), 64'd0);
      chk("c1_wrdata", 64'(bist_wrdata_o), 64'hAA_AAAA_AAAA);
      @(posedge clk_i); #1; cyc++; log_now();
      chk("c2_addr", 64'(bist_addr_o), 64'd1);
      chk("c2_wrdata", 64'(bist_wrdata_o), 64'h55_5555_5555);
      run_until(145, -1);
      chk("ysel_c1", 64'(ysel_log[1]), 64'h1);
      chk("ysel_c36", 64'(ysel_log[36]), 64'h1);
      chk("ysel_c37", 64'(ysel_log[37]), 64'h2);
      chk("ysel_c73", 64'(ysel_log[73]), 64'h4);
      chk("ysel_c108", 64'(ysel_log[108]), 64'h4);
      chk("ysel_c109", 64'(ysel_log[109]), 64'h8);
      chk("ysel_c144", 64'(ysel_log[144]), 64'h8);
      chk("done_c144", 64'(done_log[144]), 64'd0);
      chk("busy_c144", 64'(busy_log[144]), 64'd1);
      chk("clean_done_outs", all_outs(), 64'({1'b0, 4'h0, 3'd0, 40'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0}));

      // Stuck-at-0 bit 17 in RAM 2 address 5: first failing read issued in cycle 104
      stuck0[2][5] = 40'd1 << 17;
      start_run();
      run_until(145, -1);
      chk("stuck_fail_c106", 64'(fail_log[106]), 64'd0);
      chk("stuck_fail_c107", 64'(fail_log[107]), 64'd1);
      chk("stuck_done_c145", 64'(done_o), 64'd1);
      chk("stuck_fail_ram", 64'(fail_ram_o), 64'd2);
      chk("stuck_fail_addr", 64'(fail_addr_o), 64'd5);

      // Restart from DONE after a failing run
      clear_faults();
      start_run();
      chk("restart_fail_c1", 64'(fail_o), 64'd0);
      chk("restart_done_c1", 64'(done_o), 64'd0);
      chk("restart_ram_c1", 64'(fail_ram_o), 64'd0);
      run_until(145, -1);
      chk("restart_done_c145", 64'(done_o), 64'd1);
      chk("restart_fail_c145", 64'(fail_o), 64'd0);

      // Two faults: capture must hold the first (RAM 1 addr 3, read issued in cycle 48)
      stuck0[1][3] = 40'd1;
      stuck0[3][0] = 40'd1;
      start_run();
      run_until(145, -1);
      chk("two_fail_c50", 64'(fail_log[50]), 64'd0);
      chk("two_fail_c51", 64'(fail_log[51]), 64'd1);
      chk("two_fail_ram", 64'(fail_ram_o), 64'd1);
      chk("two_fail_addr", 64'(fail_addr_o), 64'd3);

      // start_i pulsed mid-run is ignored
      clear_faults();
      start_run();
      run_until(145, 50);
      chk("midstart_ysel_c73", 64'(ysel_log[73]), 64'h4);
      chk("midstart_done_c144", 64'(done_log[144]), 64'd0);
      chk("midstart_done_c145", 64'(done_o), 64'd1);
      chk("midstart_fail", 64'(fail_o), 64'd0);

      // Asynchronous reset mid-run, then a fresh clean run
      start_run();
      run_until(80, -1);
      rst_i = 1'b1;
      #1;
      chk("rst_c80_outs", all_outs(), 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("post_rst_idle", all_outs(), 64'd0);
      start_run();
      run_until(145, -1);
      chk("post_rst_ysel_c109", 64'(ysel_log[109]), 64'h8);
      chk("post_rst_done", 64'(done_o), 64'd1);
      chk("post_rst_fail", 64'(fail_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/fpga_ram_bist_ctrl.md
# fpga_ram_bist_ctrl

BIST sequencer at the head of the FPGA RAM BIST chain. It selects one RAM column at a time via a one-hot `y_select_o` and drives address, write data and write enable to it. It reads the data returned at the end of the `data_forwarding` chain and compares it against a delayed copy of the expected pattern. It reports pass/fail and the location of the first mismatch.

## Interface
Parameters:
- `ADDR_W`, 9, RAM address width; depth D = 2^ADDR_W
- `DATA_W`, 40, RAM data width
- `NUM_RAMS`, 4, number of RAM columns in the chain; width of `y_select_o`
- `RD_LAT`, 2, cycles from read issue (`bist_addr_o` valid, `bist_we_o`=0) to matching `bist_rddata_i`; legal range ≥1

Ports:
- `clk_i` in 1: single clock
- `rst_i` in 1: reset, asynchronous, active-high
- `start_i` in 1: start pulse; sampled in IDLE or DONE only
- `bist_enable_o` out 1: high while a test run is in progress
- `y_select_o` out NUM_RAMS: one-hot RAM column select; all zero outside a run
- `bist_addr_o` out ADDR_W: RAM address
- `bist_wrdata_o` out DATA_W: write data
- `bist_we_o` out 1: write enable
- `bist_rddata_i` in DATA_W: read data from the end of the forwarding chain
- `busy_o` out 1: run in progress
- `done_o` out 1: run complete; level, held until next start
- `fail_o` out 1: sticky, at least one mismatch in this run
- `fail_ram_o` out clog2(NUM_RAMS): RAM index of the first mismatch
- `fail_addr_o` out ADDR_W: address of the first mismatch

## Operation
- Pattern: P(a) = 40'hAAAA_AAAAAA if a[0]=0, else 40'h5555_555555, truncated or replicated to DATA_W.
- State machine: IDLE → W0 → R0 → DRN0 → W1 → R1 → DRN1 → (next RAM: W0 | last RAM: DONE).
  - W0: writes P(a), a = 0..D-1, one per cycle.
  - R0: reads a = 0..D-1, one per cycle; expected value is P(a).
  - W1: writes ~P(a).
  - R1: reads; expected value is ~P(a).
  - DRN0/DRN1: RD_LAT cycles. No access is issued. `y_select_o` is held.
- RAM index k runs 0..NUM_RAMS-1. `y_select_o` = 1<<k for all of that RAM's states.
- Address counter wraps D-1 → 0 on each phase exit. Phase changes happen with no idle cycle.
- Compare: each read pushes {valid, k, a, expected} into an RD_LAT-deep delay line. When the delay-line output is valid, compare it against `bist_rddata_i`.
- On a mismatch with `fail_o`=0: set `fail_o` and capture k and a. Later mismatches do not overwrite the capture.
- `start_i` in IDLE/DONE: clears `done_o`, `fail_o`, `fail_ram_o` and `fail_addr_o`; enters W0 with k=0, a=0.
- `start_i` while busy is ignored.
- `rst_i` mid-run: immediate return to IDLE. The delay line is flushed and all outputs take their reset values.

## Timing
- Reset values: all outputs 0; state IDLE.
- All outputs are registered.
- `start_i` sampled at edge 0 → first W0 access is presented in cycle 1. `busy_o` and `bist_enable_o` go high in cycle 1.
- Per RAM: 4·D + 2·RD_LAT cycles.
- Run length: NUM_RAMS·(4·D + 2·RD_LAT) cycles. The next cycle enters DONE: `done_o`=1, `busy_o`=0, `bist_enable_o`=0, `y_select_o`=0.
- Read issued in cycle n is compared in cycle n+RD_LAT. `fail_o` rises in cycle n+RD_LAT+1.
- Drain states guarantee that every compare for RAM k completes before `y_select_o` changes. This covers the one-cycle registered select in the forwarding stage.
- `bist_we_o`=1 only in W0/W1. `bist_addr_o` and `bist_wrdata_o` are 0 in IDLE, drain and DONE.

## Structure
- Shared package `fpga_ram_bist_pkg`:
  - state enum
  - pattern constants PAT_A = 40'hAAAA_AAAAAA, PAT_5 = 40'h5555_555555
  - pattern function P(a)
- Sub-module `fpga_ram_bist_expect_pipe`: parameterised RAD_LAT-deep shift register of {valid, k, a, expected}, with async clear on `rst_i`.
- Controller, counters, compare and fail capture sit in the top module.

## Test plan
Test parameters: ADDR_W=3, NUM_RAMS=4, RD_LAT=2 → D=8, 36 cycles per RAM, run = 144 cycles. The bench models 4 RAMs plus the forwarding chain.

- Clean run: start at edge 0 → `done_o`=1 in cycle 145, `fail_o`=0. `y_select_o` steps 0001 → 0010 → 0100 → 1000 at cycles 1, 37, 73, 109.
- Stuck bit: RAM 2, addr 5, bit 17 stuck-at-0 → `fail_o`=1, `fail_ram_o`=2, `fail_addr_o`=5. Captured at the first failing read; `done_o` still asserted at cycle 145.
- Two faults: RAM 1 addr 3, and RAM 3 addr 0 → capture stays at ram 1, addr 3.
- `start_i` pulsed at cycle 50 mid-run → ignored; completion timing unchanged.
- `rst_i` asserted at cycle 80 → all outputs 0 in the same cycle. A fresh start after release gives a clean full run.
- Restart from DONE after a failing run → `fail_o` and `done_o` clear in cycle 1; a clean second run ends with `fail_o`=0.
